// File: rtl/ray_dir_gen_pkg.sv
// Shared defaults and types for the per-column ray direction generator.
package ray_dir_gen_pkg;
    localparam int Q_M_DEF      = 12;
    localparam int Q_N_DEF      = 12;
    localparam int COL_BITS_DEF = 9;

    typedef logic [1:0] fsm_t;
endpackage

// File: rtl/ray_dir_gen_if.sv
// Frame-start/vector inputs and the ray valid/ready stream to the tracer.
interface ray_dir_gen_if #(
    parameter int W        = 24,
    parameter int COL_BITS = 9
);
    logic                i_frame_start;
    logic [W-1:0]        i_facingX;
    logic [W-1:0]        i_facingY;
    logic [W-1:0]        i_vplaneX;
    logic [W-1:0]        i_vplaneY;
    logic [W-1:0]        o_rayX;
    logic [W-1:0]        o_rayY;
    logic [COL_BITS-1:0] o_col;
    logic                o_valid;
    logic                i_ready;
    logic                o_busy;
    logic                o_done;

    modport master (
        output i_frame_start, i_facingX, i_facingY, i_vplaneX, i_vplaneY, i_ready,
        input  o_rayX, o_rayY, o_col, o_valid, o_busy, o_done
    );

    modport slave (
        input  i_frame_start, i_facingX, i_facingY, i_vplaneX, i_vplaneY, i_ready,
        output o_rayX, o_rayY, o_col, o_valid, o_busy, o_done
    );
endinterface

// File: rtl/ray_axis_acc.sv
// One axis of the ray sweep: guard-bit accumulator stepped by vplane, floored and saturated to W bits.
module ray_axis_acc #(
    parameter int W = 24,
    parameter int G = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic         adv,
    input  logic [W-1:0] facing,
    input  logic [W-1:0] vplane,
    output logic [W-1:0] ray
);
    localparam int AW = W + 2 + G;
    localparam logic signed [W+1:0] MAXV = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [W+1:0] MINV = {3'b111, {(W-1){1'b0}}};

    logic signed [AW-1:0]  acc;
    logic signed [AW-1:0]  step;
    logic signed [W+1:0]   base;
    logic signed [W+1:0]   whole;

    // Two extra integer bits keep facing-vplane and the full sweep from overflowing.
    assign base  = {{2{facing[W-1]}}, facing} - {{2{vplane[W-1]}}, vplane};
    assign whole = acc[AW-1:G];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc  <= '0;
            step <= '0;
        end else if (load) begin
            acc  <= {base, {G{1'b0}}};
            step <= {{(G+2){vplane[W-1]}}, vplane};
        end else if (adv) begin
            acc  <= acc + step;
        end
    end

    always_comb begin
        if (whole > MAXV)
            ray = MAXV[W-1:0];
        else if (whole < MINV)
            ray = MINV[W-1:0];
        else
            ray = whole[W-1:0];
    end
endmodule

// File: rtl/ray_dir_gen.sv
// Streams ray(c) = facing + vplane*(2c/N - 1) for every screen column after a frame-start strobe.
module ray_dir_gen
    import ray_dir_gen_pkg::*;
#(
    parameter int Q_M      = Q_M_DEF,
    parameter int Q_N      = Q_N_DEF,
    parameter int COL_BITS = COL_BITS_DEF
) (
    input  logic           clk,
    input  logic           reset_n,
    ray_dir_gen_if.slave   bus
);
    localparam int W = Q_M + Q_N;
    localparam int G = COL_BITS - 1;

    localparam fsm_t S_IDLE = 2'd0;
    localparam fsm_t S_RUN  = 2'd1;
    localparam fsm_t S_DONE = 2'd2;

    localparam logic [COL_BITS-1:0] LAST_COL = '1;

    fsm_t                state;
    fsm_t                state_nxt;
    logic [COL_BITS-1:0] col;
    logic                valid;
    logic                hs;
    logic                last_hs;
    logic                adv;

    assign hs      = valid && bus.i_ready;
    assign last_hs = hs && (col == LAST_COL);
    // A restart strobe overrides any advance, including the final one.
    assign adv     = hs && !last_hs && !bus.i_frame_start;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.i_frame_start) begin
            state_nxt = S_RUN;
        end else begin
            case (state)
                S_IDLE:  state_nxt = S_IDLE;
                S_RUN:   if (last_hs) state_nxt = S_DONE;
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        valid       = (state == S_RUN);
        bus.o_busy  = (state == S_RUN) || (state == S_DONE);
        bus.o_done  = (state == S_DONE);
    end

    // Column wraps to 0 naturally after the last handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            col <= '0;
        else if (bus.i_frame_start)
            col <= '0;
        else if (hs)
            col <= col + 1'b1;
    end

    assign bus.o_valid = valid;
    assign bus.o_col   = col;

    ray_axis_acc #(.W(W), .G(G)) u_acc_x (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (bus.i_frame_start),
        .adv     (adv),
        .facing  (bus.i_facingX),
        .vplane  (bus.i_vplaneX),
        .ray     (bus.o_rayX)
    );

    ray_axis_acc #(.W(W), .G(G)) u_acc_y (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (bus.i_frame_start),
        .adv     (adv),
        .facing  (bus.i_facingY),
        .vplane  (bus.i_vplaneY),
        .ray     (bus.o_rayY)
    );
endmodule

// File: tb/tb_ray_dir_gen.sv
// Scoreboard bench for ray_dir_gen: driver pushes frames, monitor checks every presented ray.
module tb_ray_dir_gen;
    localparam int QM = 12;
    localparam int QN = 12;
    localparam int CB = 9;
    localparam int W  = QM + QN;
    localparam int N  = 1 << CB;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    ray_dir_gen_if #(.W(W), .COL_BITS(CB)) bus();

    ray_dir_gen #(.Q_M(QM), .Q_N(QN), .COL_BITS(CB)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        int           col;
        logic [W-1:0] x;
        logic [W-1:0] y;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    // driver -> monitor hand-off (each written by one process only)
    int           load_seq = 0;
    int           load_seen = 0;
    logic [W-1:0] ld_fx, ld_fy, ld_vx, ld_vy;
    int           dir_case = 0;
    int           fin_req = 0;
    int           fin_ack = 0;

    // ray(c) = floor(facing - vplane + 2*c*vplane/N), clamped to signed W bits
    function automatic logic [W-1:0] ray_ref(input logic [W-1:0] f, input logic [W-1:0] v, input int c);
        longint fl, vl, num, qq, maxv, minv;
        fl   = longint'($signed(f));
        vl   = longint'($signed(v));
        num  = (fl - vl) * N + 2 * longint'(c) * vl;
        qq   = num / N;
        if ((num % N) != 0 && num < 0) qq = qq - 1;
        maxv = (longint'(1) << (W-1)) - 1;
        minv = -(longint'(1) << (W-1));
        if (qq > maxv) qq = maxv;
        if (qq < minv) qq = minv;
        return qq[W-1:0];
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic [CB-1:0] p_col;
        logic [W-1:0]  p_x, p_y, last_x;
        logic          p_stall, p_fs, exp_done, nd;
        int            idle_run, hs_cnt;
        exp_t          e;
        p_stall = 0; p_fs = 0; exp_done = 0; idle_run = 0; hs_cnt = 0;
        p_col = '0; p_x = '0; p_y = '0; last_x = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                chk("rst_valid", bus.o_valid, 0);
                chk("rst_busy",  bus.o_busy,  0);
                chk("rst_done",  bus.o_done,  0);
                chk("rst_col",   bus.o_col,   0);
                chk("rst_rayx",  bus.o_rayX,  0);
                chk("rst_rayy",  bus.o_rayY,  0);
                q.delete();
                exp_done = 0; p_stall = 0; idle_run = 0;
                load_seen = load_seq;
            end else begin
                if (load_seq != load_seen) begin
                    load_seen = load_seq;
                    q.delete();
                    for (int c = 0; c < N; c++)
                        q.push_back('{col: c, x: ray_ref(ld_fx, ld_vx, c), y: ray_ref(ld_fy, ld_vy, c)});
                    hs_cnt = 0;
                end
                chk("valid", bus.o_valid, (q.size() != 0) ? 1 : 0);
                chk("done",  bus.o_done, exp_done);
                chk("busy",  bus.o_busy, (q.size() != 0 || exp_done) ? 1 : 0);
                if (p_stall && !p_fs) begin
                    chk("hold_col",  bus.o_col,  p_col);
                    chk("hold_rayx", bus.o_rayX, p_x);
                    chk("hold_rayy", bus.o_rayY, p_y);
                end
                nd = 0;
                if (bus.o_valid && bus.i_ready) begin
                    idle_run = 0;
                    if (q.size() == 0) begin
                        chk("hs_unexpected", 1, 0);
                    end else begin
                        e = q.pop_front();
                        hs_cnt++;
                        chk("col",  bus.o_col,  e.col);
                        chk("rayx", bus.o_rayX, e.x);
                        chk("rayy", bus.o_rayY, e.y);
                        if (dir_case == 1) begin
                            if (e.col == 0)   chk("nom_c0_x",   bus.o_rayX, 24'h000800);
                            if (e.col == 0)   chk("nom_c0_y",   bus.o_rayY, 24'h001000);
                            if (e.col == 256) chk("nom_c256_x", bus.o_rayX, 24'h000000);
                            if (e.col == 511) chk("nom_c511_x", bus.o_rayX, 24'hFFF808);
                        end else if (dir_case == 2) begin
                            if (e.col == 255) chk("grd_c255_x", bus.o_rayX, 24'h0000FF);
                            if (e.col == 256) chk("grd_c256_x", bus.o_rayX, 24'h000100);
                            if (e.col == 511) chk("grd_c511_x", bus.o_rayX, 24'h000100);
                            if (e.col > 0)
                                chk("grd_mono", ($signed(bus.o_rayX) >= $signed(last_x)) ? 1 : 0, 1);
                        end else if (dir_case == 3) begin
                            if (e.col == 0) chk("sat_c0_x", bus.o_rayX, 24'h7FFFFF);
                            chk("sat_nowrap", bus.o_rayX[W-1], 0);
                        end
                        last_x = bus.o_rayX;
                        if (e.col == N-1 && !bus.i_frame_start) begin
                            nd = 1;
                            chk("hs_count", hs_cnt, N);
                        end
                    end
                end else if (q.size() != 0) begin
                    idle_run++;
                    if (idle_run == 300) chk("stall_timeout", idle_run, 0);
                end
                exp_done = nd;
                p_stall  = bus.o_valid && !bus.i_ready;
                p_fs     = bus.i_frame_start;
                p_col    = bus.o_col;
                p_x      = bus.o_rayX;
                p_y      = bus.o_rayY;
                if (fin_req != fin_ack) begin
                    chk("final_drain", q.size(), 0);
                    fin_ack = fin_req;
                end
            end
        end
    end

    // ---------------- driver ----------------
    function automatic logic [W-1:0] rnd_vec();
        logic [W-1:0] v;
        int sh;
        v  = W'($urandom);
        sh = $urandom_range(14, 0);
        return W'($signed(v) >>> sh);
    endfunction

    // Vectors are only meaningful on a strobe; otherwise they toggle randomly.
    task automatic step(input logic fs, input logic rdy,
                        input logic [W-1:0] fx, input logic [W-1:0] fy,
                        input logic [W-1:0] vx, input logic [W-1:0] vy);
        bus.i_frame_start = fs;
        bus.i_ready       = rdy;
        bus.i_facingX     = fs ? fx : rnd_vec();
        bus.i_facingY     = fs ? fy : rnd_vec();
        bus.i_vplaneX     = fs ? vx : rnd_vec();
        bus.i_vplaneY     = fs ? vy : rnd_vec();
        @(posedge clk); #1;
        if (fs) begin
            ld_fx = fx; ld_fy = fy; ld_vx = vx; ld_vy = vy;
            load_seq++;
        end
        bus.i_frame_start = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 1'b1, '0, '0, '0, '0);
    endtask

    task automatic drain(input int pready);
        for (int k = 0; k < 5000; k++) begin
            if (load_seen == load_seq && q.size() == 0) break;
            step(0, ($urandom_range(99) < pready) ? 1'b1 : 1'b0, '0, '0, '0, '0);
        end
        idle(3);
    endtask

    task automatic run_frame(input logic [W-1:0] fx, input logic [W-1:0] fy,
                             input logic [W-1:0] vx, input logic [W-1:0] vy,
                             input int pready, input int dcase);
        dir_case = dcase;
        step(1, 1'b1, fx, fy, vx, vy);
        drain(pready);
        dir_case = 0;
    endtask

    initial begin : driver
        bus.i_frame_start = 0; bus.i_ready = 0;
        bus.i_facingX = '0; bus.i_facingY = '0; bus.i_vplaneX = '0; bus.i_vplaneY = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        idle(10);

        run_frame(24'h000000, 24'h001000, 24'hFFF800, 24'h000000, 100, 1);
        run_frame(24'h000100, 24'h000000, 24'h000001, 24'h000000, 100, 2);
        run_frame(24'h7FF000, 24'h000000, 24'h800000, 24'h000000, 100, 3);

        for (int f = 0; f < 4; f++)
            run_frame(rnd_vec(), rnd_vec(), rnd_vec(), rnd_vec(), 60, 0);

        // restart in the middle of a stream
        step(1, 1'b1, rnd_vec(), rnd_vec(), rnd_vec(), rnd_vec());
        for (int k = 0; k < 100; k++) step(0, 1'b1, '0, '0, '0, '0);
        step(1, 1'b1, 24'h001234, 24'hFFE000, 24'h000800, 24'h000400);
        drain(100);

        // restart coincident with the last handshake
        step(1, 1'b1, rnd_vec(), rnd_vec(), rnd_vec(), rnd_vec());
        for (int k = 0; k < N-1; k++) step(0, 1'b1, '0, '0, '0, '0);
        step(1, 1'b1, 24'hFFF000, 24'h002000, 24'h001000, 24'hFFFC00);
        drain(80);

        // asynchronous reset mid-stream, then idle with no strobe
        step(1, 1'b1, rnd_vec(), rnd_vec(), rnd_vec(), rnd_vec());
        for (int k = 0; k < 50; k++) step(0, 1'b1, '0, '0, '0, '0);
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        idle(20);

        fin_req++;
        for (int k = 0; k < 20; k++) begin
            if (fin_ack == fin_req) break;
            @(negedge clk);
        end
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
